// File: rtl/div_unit_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg: definitions shared by the ALU writeback path and the divider.
//   - AluFlags bit positions (Z, C, V, S)
//   - divider FSM state enum
//   - flag word reported on overflow / divide-by-zero
//   - div_flags(): flag word for a normally completed division
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_S = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // S=1, V=1, Z=0, C=0
    localparam logic [3:0] DIV_FLAGS_OVF = 4'b1100;

    // Normal completion: Z on an all-zero result, S mirrors the quotient MSB.
    function automatic logic [3:0] div_flags(input logic [15:0] r);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_Z] = (r == 16'h0000);
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = 1'b0;
        f[FLAG_S] = r[7];
        return f;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// ----------------------------------------------------------------------------
// div_unit_if: request/response bundle between the execute stage (master)
// and the divider (slave).
//   start  : one-cycle request          cancel : abort in-flight division
//   A      : 16-bit dividend            B      : 8-bit divisor
//   busy   : division in progress       done   : one-cycle completion pulse
//   div0   : divide-by-zero pulse       R      : {remainder, quotient} or A
//   flags  : {S, V, C, Z}
// ----------------------------------------------------------------------------
interface div_unit_if;
    logic        start;
    logic        cancel;
    logic [15:0] A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic        div0;
    logic [15:0] R;
    logic [3:0]  flags;

    modport master (
        output start, cancel, A, B,
        input  busy, done, div0, R, flags
    );

    modport slave (
        input  start, cancel, A, B,
        output busy, done, div0, R, flags
    );
endinterface

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step: one combinational restoring-division step.
//   i_rem : 9-bit {partial remainder, next dividend bit}
//   i_div : 8-bit divisor
//   o_rem : next 8-bit partial remainder
//   o_q   : quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step (
    input  logic [8:0] i_rem,
    input  logic [7:0] i_div,
    output logic [7:0] o_rem,
    output logic       o_q
);
    assign o_q = (i_rem >= {1'b0, i_div});

    // The incoming remainder is always below the divisor, so a successful
    // subtraction leaves a value below the divisor as well; modulo-256
    // arithmetic on the low byte therefore gives the exact difference.
    assign o_rem = o_q ? (i_rem[7:0] - i_div) : i_rem[7:0];
endmodule

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit: sequential 16/8 unsigned divider for the DIV instruction.
//   clk     : core clock
//   reset_n : asynchronous active-low reset
//   bus     : div_unit_if.slave (start, cancel, A, B -> busy, done, div0,
//             R, flags)
// Result packing: R = {remainder, quotient}; on overflow or B == 0 the
// dividend is returned unchanged with flags S=1, V=1.
// Configuration macro DIV_RADIX4_EN: two chained restoring steps per cycle
// (4 ITER cycles) instead of one (8 ITER cycles).
// ----------------------------------------------------------------------------
module div_unit
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    div_unit_if.slave bus
);
    div_state_t  r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_div0;
    logic [15:0] r_r;
    logic [3:0]  r_flags;
    logic [2:0]  r_cnt;

    // Working state: partial remainder, dividend bits still to consume
    // (shifted out MSB-first while quotient bits shift in), latched divisor.
    logic [7:0]  r_rem;
    logic [7:0]  r_lo;
    logic [7:0]  r_div;

    logic [7:0]  w_rem_nxt;
    logic [7:0]  w_lo_nxt;
    logic        w_accept;

`ifdef DIV_RADIX4_EN
    localparam logic [2:0] LAST_CNT = 3'd3;
    logic [7:0] w_rem_s0;
    logic       w_q_s0;
    logic       w_q_s1;

    div_step u_step0 (
        .i_rem ({r_rem, r_lo[7]}),
        .i_div (r_div),
        .o_rem (w_rem_s0),
        .o_q   (w_q_s0)
    );

    div_step u_step1 (
        .i_rem ({w_rem_s0, r_lo[6]}),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_q   (w_q_s1)
    );

    assign w_lo_nxt = {r_lo[5:0], w_q_s0, w_q_s1};
`else
    localparam logic [2:0] LAST_CNT = 3'd7;
    logic w_q_s0;

    div_step u_step0 (
        .i_rem ({r_rem, r_lo[7]}),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_q   (w_q_s0)
    );

    assign w_lo_nxt = {r_lo[6:0], w_q_s0};
`endif

    assign w_accept = (r_state == ST_IDLE) && bus.start;

    // Control and architectural outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_r     <= 16'h0000;
            r_flags <= 4'h0;
            r_cnt   <= 3'd0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.B == 8'h00) begin
                            r_r     <= bus.A;
                            r_flags <= DIV_FLAGS_OVF;
                            r_div0  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (bus.A[15:8] >= bus.B) begin
                            // Quotient would not fit in 8 bits.
                            r_r     <= bus.A;
                            r_flags <= DIV_FLAGS_OVF;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= 3'd0;
                            r_busy  <= 1'b1;
                            r_state <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    if (bus.cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == LAST_CNT) begin
                            r_r     <= {w_rem_nxt, w_lo_nxt};
                            r_flags <= div_flags({w_rem_nxt, w_lo_nxt});
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rem <= bus.A[15:8];
            r_lo  <= bus.A[7:0];
            r_div <= bus.B;
        end else if (r_state == ST_ITER) begin
            r_rem <= w_rem_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.div0  = r_div0;
    assign bus.R     = r_r;
    assign bus.flags = r_flags;
endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit: self-checking bench for div_unit (either radix build).
// ----------------------------------------------------------------------------
module tb_div_unit;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    div_unit_if bus ();

    div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_RADIX4_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 9;
`endif

    // Reference: plain integer division with the documented exceptions.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] r, output logic [3:0] f,
                                  output bit d0, output bit early);
        int unsigned q, rm;
        d0 = 0;
        early = 0;
        if (b == 8'h00) begin
            r = a; f = 4'b1100; d0 = 1; early = 1;
        end else begin
            q  = int'(a) / int'(b);
            rm = int'(a) % int'(b);
            if (q > 255) begin
                r = a; f = 4'b1100; early = 1;
            end else begin
                r = {rm[7:0], q[7:0]};
                f = {q[7], 1'b0, 1'b0, (r == 16'h0000)};
            end
        end
    endfunction

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Present a start for exactly one cycle n; returns in cycle n+1.
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        next_cycle();
        bus.start = 1'b0;
    endtask

    // Watch for done (bounded). Cycle numbers are relative to the start cycle;
    // done_cyc stays -1 when the bound expires. Returns at the negedge of done.
    task automatic wait_done(input int first, output int done_cyc, output int busy_cnt,
                             output bit busy_at_done, output bit div0_at_done);
        int cyc;
        cyc = first;
        done_cyc = -1;
        busy_cnt = 0;
        busy_at_done = 0;
        div0_at_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) begin
                done_cyc     = cyc;
                busy_at_done = bus.busy;
                div0_at_done = bus.div0;
                break;
            end
            if (bus.busy) busy_cnt++;
            next_cycle();
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.div0 !== 1'b0) begin failures++; $display("FAIL reset_div0 got=%b exp=0", bus.div0); end
        checks++; if (bus.R !== 16'h0000) begin failures++; $display("FAIL reset_R got=%h exp=0000", bus.R); end
        checks++; if (bus.flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [15:0] va [5];
        logic [7:0]  vb [5];
        logic [15:0] er [5];
        logic [3:0]  ef [5];
        bit          ed [5];
        int          el [5];
        int dc, bc;
        bit bd, d0;
        va = '{16'h1234, 16'h1234, 16'h00FF, 16'h0000, 16'h00FF};
        vb = '{8'h56,    8'h12,    8'h00,    8'h05,    8'h01};
        er = '{16'h1036, 16'h1234, 16'h00FF, 16'h0000, 16'h00FF};
        ef = '{4'b0000,  4'b1100,  4'b1100,  4'b0001,  4'b1000};
        ed = '{0, 0, 1, 0, 0};
        el = '{LAT, 1, 1, LAT, LAT};
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i]);
            wait_done(1, dc, bc, bd, d0);
            checks++; if (dc !== el[i]) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, dc, el[i]); end
            checks++; if (bc !== el[i] - 1) begin failures++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, el[i] - 1); end
            checks++; if (bd !== 1'b0) begin failures++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, bd); end
            checks++; if (d0 !== ed[i]) begin failures++; $display("FAIL dir%0d_div0 got=%b exp=%b", i, d0, ed[i]); end
            checks++; if (bus.R !== er[i]) begin failures++; $display("FAIL dir%0d_R got=%h exp=%h", i, bus.R, er[i]); end
            checks++; if (bus.flags !== ef[i]) begin failures++; $display("FAIL dir%0d_flags got=%b exp=%b", i, bus.flags, ef[i]); end
            next_cycle();
            @(negedge clk);
            checks++; if ({bus.done, bus.div0} !== 2'b00) begin failures++; $display("FAIL dir%0d_pulse_width got=%b exp=00", i, {bus.done, bus.div0}); end
            checks++; if (bus.R !== er[i]) begin failures++; $display("FAIL dir%0d_R_hold got=%h exp=%h", i, bus.R, er[i]); end
        end
    endtask

    task automatic test_random;
        logic [15:0] a, mr;
        logic [7:0]  b;
        logic [3:0]  mf;
        bit md0, early, bd, d0;
        int dc, bc, mode;
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 9));
            b = 8'($urandom_range(0, 255));
            a = 16'($urandom_range(0, 65535));
            if (mode == 0) b = 8'h00;
            else if (mode > 2 && b != 8'h00) a[15:8] = 8'($urandom_range(0, int'(b) - 1));
            model(a, b, mr, mf, md0, early);
            issue(a, b);
            wait_done(1, dc, bc, bd, d0);
            checks++; if (dc !== (early ? 1 : LAT)) begin failures++; $display("FAIL rnd%0d_latency a=%h b=%h got=%0d exp=%0d", i, a, b, dc, early ? 1 : LAT); end
            checks++; if (bus.R !== mr) begin failures++; $display("FAIL rnd%0d_R a=%h b=%h got=%h exp=%h", i, a, b, bus.R, mr); end
            checks++; if (bus.flags !== mf) begin failures++; $display("FAIL rnd%0d_flags a=%h b=%h got=%b exp=%b", i, a, b, bus.flags, mf); end
            checks++; if (d0 !== md0) begin failures++; $display("FAIL rnd%0d_div0 a=%h b=%h got=%b exp=%b", i, a, b, d0, md0); end
            next_cycle();
        end
    endtask

    task automatic test_start_ignored;
        int dc, bc;
        bit bd, d0;
        issue(16'h1234, 8'h56);       // now cycle n+1
        next_cycle();                 // n+2
        next_cycle();                 // n+3
        bus.A = 16'h0042; bus.B = 8'h07; bus.start = 1'b1;
        next_cycle();                 // n+4
        bus.start = 1'b0;
        wait_done(4, dc, bc, bd, d0);
        checks++; if (dc !== LAT) begin failures++; $display("FAIL ignored_latency got=%0d exp=%0d", dc, LAT); end
        checks++; if (bus.R !== 16'h1036) begin failures++; $display("FAIL ignored_R got=%h exp=1036", bus.R); end
        next_cycle();
        @(negedge clk);
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin failures++; $display("FAIL ignored_no_second_op got=%b exp=00", {bus.busy, bus.done}); end
        next_cycle();
    endtask

    task automatic test_cancel;
        int dc, bc;
        bit bd, d0, seen;
        issue(16'h00FF, 8'h01);
        wait_done(1, dc, bc, bd, d0);
        next_cycle();
        issue(16'h1234, 8'h56);       // n+1
        next_cycle();                 // n+2
        next_cycle();                 // n+3
        next_cycle();                 // n+4
        bus.cancel = 1'b1;
        next_cycle();
        bus.cancel = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%b exp=0", bus.busy); end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL cancel_no_done got=%b exp=0", seen); end
        checks++; if (bus.R !== 16'h00FF) begin failures++; $display("FAIL cancel_R_kept got=%h exp=00ff", bus.R); end
        checks++; if (bus.flags !== 4'b1000) begin failures++; $display("FAIL cancel_flags_kept got=%b exp=1000", bus.flags); end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        bit seen;
        issue(16'h1234, 8'h56);       // n+1
        next_cycle();                 // n+2
        next_cycle();                 // n+3
        next_cycle();                 // n+4
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done, bus.div0} !== 3'b000) begin failures++; $display("FAIL rstmid_ctrl got=%b exp=000", {bus.busy, bus.done, bus.div0}); end
        checks++; if (bus.R !== 16'h0000) begin failures++; $display("FAIL rstmid_R got=%h exp=0000", bus.R); end
        checks++; if (bus.flags !== 4'h0) begin failures++; $display("FAIL rstmid_flags got=%b exp=0000", bus.flags); end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b exp=0", seen); end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        int dc, bc;
        bit bd, d0, seen;
        issue(16'h1234, 8'h56);
        wait_done(1, dc, bc, bd, d0);
        // Held from the done cycle: ignored there, accepted in the next IDLE
        // cycle even with cancel asserted alongside.
        bus.A = 16'h0000; bus.B = 8'h05; bus.start = 1'b1; bus.cancel = 1'b1;
        next_cycle();
        next_cycle();
        bus.start = 1'b0; bus.cancel = 1'b0;
        wait_done(1, dc, bc, bd, d0);
        checks++; if (dc !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", dc, LAT); end
        checks++; if (bus.R !== 16'h0000) begin failures++; $display("FAIL b2b_R got=%h exp=0000", bus.R); end
        checks++; if (bus.flags !== 4'b0001) begin failures++; $display("FAIL b2b_flags got=%b exp=0001", bus.flags); end
        // Start only during the done cycle must be dropped.
        bus.A = 16'h1234; bus.B = 8'h56; bus.start = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL done_cycle_start_ignored got=%b exp=0", seen); end
        checks++; if (bus.R !== 16'h0000) begin failures++; $display("FAIL done_cycle_R got=%h exp=0000", bus.R); end
        next_cycle();
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.A      = 16'h0000;
        bus.B      = 8'h00;
        test_reset();
        next_cycle();
        test_directed();
        test_random();
        test_start_ignored();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
